// File: rtl/uart_tx_cfg_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg_if
// Purpose  : valid/ready write port feeding the UART transmitter FIFO
// Revision : 1.0
// ============================================================================
interface uart_tx_cfg_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data_i;
    logic                 valid_i;
    logic                 ready_o;

    modport master (
        output tx_data_i,
        output valid_i,
        input  ready_o
    );

    modport slave (
        input  tx_data_i,
        input  valid_i,
        output ready_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_cfg
// Purpose  : FIFO-buffered UART transmitter with build-time frame format
// Revision : 1.0
// ============================================================================
module uart_tx_cfg #(
    parameter int CLK_DIV    = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  wire                          clk_i,
    input  wire                          reset_i,
    uart_tx_cfg_if.slave                 tx_if,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic [$clog2(FIFO_DEPTH):0]  level_o
);
    localparam int          AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] c_DEPTH     = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0] c_RELOAD    = 16'(CLK_DIV - 1);
    localparam logic [3:0]  c_LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]  c_LAST_STOP = 4'(STOP_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

    generate
        if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
            $error("uart_tx_cfg: CLK_DIV must be 2..65535");
        end
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_cfg: DATA_BITS must be 5..9");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
            $error("uart_tx_cfg: FIFO_DEPTH must be a power of 2, at least 2");
        end
    endgenerate

    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_level;

    logic [2:0]           r_state;
    logic [15:0]          r_cnt;
    logic [3:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;

    logic                 w_ready;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_nonempty;
    logic                 w_bit_end;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_head_par;
    logic [DATA_BITS-1:0] w_shift_next;

    // Ready looks only at registered occupancy, so a full FIFO refuses a word
    // even on the edge where the transmitter pops.
    assign w_nonempty   = (r_level != '0);
    assign w_ready      = (r_level < c_DEPTH) && !reset_i;
    assign w_push       = tx_if.valid_i && w_ready;
    assign w_bit_end    = (r_cnt == 16'd0);
    assign w_pop        = w_nonempty &&
                          ((r_state == c_ST_IDLE) ||
                           ((r_state == c_ST_STOP) && w_bit_end && (r_bit_idx == c_LAST_STOP)));
    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_par   = (PARITY == 2) ? ~(^w_head) : ^w_head;
    assign w_shift_next = {1'b0, r_shift[DATA_BITS-1:1]};

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_if.tx_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push && !w_pop) begin
                r_level <= r_level + (AW+1)'(1);
            end else if (!w_push && w_pop) begin
                r_level <= r_level - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 16'd0;
            r_bit_idx <= 4'd0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
        end else if (w_pop) begin
            // Popping always starts a frame, from IDLE or straight out of STOP.
            r_state   <= c_ST_START;
            r_shift   <= w_head;
            r_par     <= w_head_par;
            r_tx      <= 1'b0;
            r_cnt     <= c_RELOAD;
            r_bit_idx <= 4'd0;
        end else begin
            if (r_state != c_ST_IDLE) begin
                r_cnt <= w_bit_end ? c_RELOAD : (r_cnt - 16'd1);
            end
            case (r_state)
                c_ST_IDLE: begin
                    r_tx <= 1'b1;
                end
                c_ST_START: begin
                    if (w_bit_end) begin
                        r_state   <= c_ST_DATA;
                        r_tx      <= r_shift[0];
                        r_shift   <= w_shift_next;
                        r_bit_idx <= 4'd0;
                    end
                end
                c_ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == c_LAST_DATA) begin
                            r_bit_idx <= 4'd0;
                            if (PARITY != 0) begin
                                r_state <= c_ST_PARITY;
                                r_tx    <= r_par;
                            end else begin
                                r_state <= c_ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                            r_tx      <= r_shift[0];
                            r_shift   <= w_shift_next;
                        end
                    end
                end
                c_ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= c_ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == c_LAST_STOP) begin
                            r_state <= c_ST_IDLE;
                        end else begin
                            r_bit_idx <= r_bit_idx + 4'd1;
                        end
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_if.ready_o = w_ready;
    assign tx_o          = r_tx;
    assign busy_o        = (r_state != c_ST_IDLE) || w_nonempty;
    assign level_o       = r_level;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_cfg
// Purpose  : self-checking bench for uart_tx_cfg (8N1, 8E1, 8O1, 9O2 at CLK_DIV=4)
// Revision : 1.0
// ============================================================================
module tb_uart_tx_cfg;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] v = 4'b0;
    logic [8:0] d [4];

    wire [3:0]      tx_w;
    wire [3:0]      busy_w;
    wire [3:0]      rdy_w;
    wire [3:0][2:0] lvl_w;

    int checks   = 0;
    int failures = 0;

    int nb_c  [4] = '{8, 8, 8, 9};
    int par_c [4] = '{0, 1, 2, 2};
    int sb_c  [4] = '{1, 1, 1, 2};

    logic exp_q [$];

    always #5 clk = ~clk;

    uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
    uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
    uart_tx_cfg_if #(.DATA_BITS(9)) if3 ();

    assign if0.valid_i = v[0];  assign if0.tx_data_i = d[0][7:0];  assign rdy_w[0] = if0.ready_o;
    assign if1.valid_i = v[1];  assign if1.tx_data_i = d[1][7:0];  assign rdy_w[1] = if1.ready_o;
    assign if2.valid_i = v[2];  assign if2.tx_data_i = d[2][7:0];  assign rdy_w[2] = if2.ready_o;
    assign if3.valid_i = v[3];  assign if3.tx_data_i = d[3];       assign rdy_w[3] = if3.ready_o;

    uart_tx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk_i(clk), .reset_i(rst), .tx_if(if0.slave),
        .tx_o(tx_w[0]), .busy_o(busy_w[0]), .level_o(lvl_w[0]));
    uart_tx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk_i(clk), .reset_i(rst), .tx_if(if1.slave),
        .tx_o(tx_w[1]), .busy_o(busy_w[1]), .level_o(lvl_w[1]));
    uart_tx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk_i(clk), .reset_i(rst), .tx_if(if2.slave),
        .tx_o(tx_w[2]), .busy_o(busy_w[2]), .level_o(lvl_w[2]));
    uart_tx_cfg #(.CLK_DIV(CLK_DIV), .DATA_BITS(9), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
        .clk_i(clk), .reset_i(rst), .tx_if(if3.slave),
        .tx_o(tx_w[3]), .busy_o(busy_w[3]), .level_o(lvl_w[3]));

    // Reference line waveform: start, data LSB first, parity from the count of ones, stop bits.
    function automatic void add_frame(input int nb, input int par, input int sb, input logic [8:0] w);
        logic frame_bits [$];
        int ones = 0;
        frame_bits.push_back(1'b0);
        for (int i = 0; i < nb; i++) begin
            frame_bits.push_back(w[i]);
            if (w[i]) ones++;
        end
        if (par == 1) frame_bits.push_back((ones % 2) == 1);
        if (par == 2) frame_bits.push_back((ones % 2) == 0);
        for (int i = 0; i < sb; i++) frame_bits.push_back(1'b1);
        foreach (frame_bits[i]) begin
            for (int r = 0; r < CLK_DIV; r++) exp_q.push_back(frame_bits[i]);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int k);
        int n = 0;
        while (rdy_w[k] !== 1'b1 && n < 2000) begin
            tick();
            n++;
        end
        if (rdy_w[k] !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL wait_ready dut%0d: ready=%b required 1 within 2000 cycles", k, rdy_w[k]);
        end
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy_w[k] !== 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        if (busy_w[k] !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle dut%0d: busy=%b required 0 within 2000 cycles", k, busy_w[k]);
        end
    endtask

    task automatic push(input int k, input logic [8:0] w);
        wait_ready(k);
        d[k] = w;
        v[k] = 1'b1;
        tick();
        v[k] = 1'b0;
    endtask

    task automatic compare_wave(input string name, input logic cap [$]);
        int bad = -1;
        checks++;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (bad < 0 && (i >= cap.size() || cap[i] !== exp_q[i])) bad = i;
        end
        if (bad >= 0) begin
            failures++;
            $display("FAIL %s: tx at cycle %0d = %b required %b", name, bad,
                     (bad < cap.size()) ? cap[bad] : 1'bx, exp_q[bad]);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        v[0] = 1'b1;
        d[0] = 9'h0A5;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tx_w[k] !== 1'b1 || busy_w[k] !== 1'b0 || lvl_w[k] !== 3'd0 || rdy_w[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_state dut%0d: tx=%b busy=%b level=%0d ready=%b required 1 0 0 0",
                         k, tx_w[k], busy_w[k], lvl_w[k], rdy_w[k]);
            end
        end
        v[0] = 1'b0;
        rst  = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rdy_w[k] !== 1'b1 || lvl_w[k] !== 3'd0) begin
                failures++;
                $display("FAIL reset_release dut%0d: ready=%b level=%0d required 1 0", k, rdy_w[k], lvl_w[k]);
            end
        end
    endtask

    task automatic test_frame(input int k, input logic [8:0] w);
        logic cap [$];
        wait_idle(k);
        exp_q.delete();
        exp_q.push_back(1'b1);
        add_frame(nb_c[k], par_c[k], sb_c[k], w);
        push(k, w);
        cap.push_back(tx_w[k]);
        for (int i = 1; i < exp_q.size(); i++) begin
            tick();
            cap.push_back(tx_w[k]);
        end
        compare_wave($sformatf("frame dut%0d word=%03h", k, w), cap);
        checks++;
        if (busy_w[k] !== 1'b1) begin
            failures++;
            $display("FAIL busy_last_stop dut%0d: busy=%b required 1", k, busy_w[k]);
        end
        tick();
        checks++;
        if (busy_w[k] !== 1'b0 || tx_w[k] !== 1'b1) begin
            failures++;
            $display("FAIL busy_after_frame dut%0d: busy=%b tx=%b required 0 1", k, busy_w[k], tx_w[k]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [6];
        logic cap [$];
        int idx = 0;
        int acc_at_fall = -1;
        int maxlev = 0;
        int rise_c = -1;
        int acc6_c = -1;
        logic prev_rdy, prev_tx, rdy_now;
        for (int i = 0; i < 6; i++) begin
            logic [7:0] w;
            bit dup;
            do begin
                w = 8'($urandom);
                dup = 1'b0;
                for (int j = 0; j < i; j++) if (words[j] == w) dup = 1'b1;
            end while (dup);
            words[i] = w;
        end
        wait_idle(0);
        wait_ready(0);
        exp_q.delete();
        exp_q.push_back(1'b1);
        for (int i = 0; i < 6; i++) add_frame(8, 0, 1, {1'b0, words[i]});
        d[0] = {1'b0, words[0]};
        v[0] = 1'b1;
        prev_rdy = rdy_w[0];
        prev_tx  = tx_w[0];
        for (int c = 0; c < exp_q.size(); c++) begin
            rdy_now = rdy_w[0];
            tick();
            if (v[0] && rdy_now) begin
                idx++;
                if (idx == 6) acc6_c = c;
                if (idx < 6) d[0] = {1'b0, words[idx]};
                else v[0] = 1'b0;
            end
            cap.push_back(tx_w[0]);
            if (int'(lvl_w[0]) > maxlev) maxlev = int'(lvl_w[0]);
            if (acc_at_fall < 0 && rdy_w[0] === 1'b0) acc_at_fall = idx;
            if (prev_rdy === 1'b0 && rdy_w[0] === 1'b1) begin
                // Ready can only come back because a pop just started a new frame.
                checks++;
                if (!(tx_w[0] === 1'b0 && prev_tx === 1'b1)) begin
                    failures++;
                    $display("FAIL ready_rise_after_pop: tx=%b prev_tx=%b required 0 1", tx_w[0], prev_tx);
                end
                if (rise_c < 0) begin
                    rise_c = c;
                    checks++;
                    if (idx != 5 || v[0] !== 1'b1 || lvl_w[0] !== 3'd3) begin
                        failures++;
                        $display("FAIL full_pop_no_accept: accepted=%0d valid=%b level=%0d required 5 1 3",
                                 idx, v[0], lvl_w[0]);
                    end
                end
            end
            prev_rdy = rdy_w[0];
            prev_tx  = tx_w[0];
        end
        checks++;
        if (acc_at_fall != 5) begin
            failures++;
            $display("FAIL accepted_before_full: got %0d required 5", acc_at_fall);
        end
        checks++;
        if (maxlev != 4) begin
            failures++;
            $display("FAIL max_level: got %0d required 4", maxlev);
        end
        checks++;
        if (idx != 6 || acc6_c != rise_c + 1) begin
            failures++;
            $display("FAIL accept_after_pop: accepted=%0d at cycle %0d required 6 at cycle %0d",
                     idx, acc6_c, rise_c + 1);
        end
        compare_wave("back_to_back stream", cap);
        tick();
        checks++;
        if (busy_w[0] !== 1'b0 || lvl_w[0] !== 3'd0) begin
            failures++;
            $display("FAIL b2b_drained: busy=%b level=%0d required 0 0", busy_w[0], lvl_w[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic line_bad = 1'b0;
        wait_idle(0);
        push(0, 9'h055);
        push(0, 9'($urandom_range(0, 255)));
        push(0, 9'($urandom_range(0, 255)));
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (tx_w[0] !== 1'b0 || lvl_w[0] !== 3'd2 || busy_w[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_setup: tx=%b level=%0d busy=%b required 0 2 1", tx_w[0], lvl_w[0], busy_w[0]);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (tx_w[0] !== 1'b1 || lvl_w[0] !== 3'd0 || busy_w[0] !== 1'b0 || rdy_w[0] !== 1'b0) begin
            failures++;
            $display("FAIL mid_frame_reset: tx=%b level=%0d busy=%b ready=%b required 1 0 0 0",
                     tx_w[0], lvl_w[0], busy_w[0], rdy_w[0]);
        end
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) line_bad = 1'b1;
        end
        checks++;
        if (line_bad) begin
            failures++;
            $display("FAIL post_reset_quiet: line or busy active after reset, required idle");
        end
        test_frame(0, 9'($urandom_range(0, 255)));
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 3; n++) begin
                test_frame(k, (nb_c[k] == 9) ? 9'($urandom_range(0, 511)) : 9'($urandom_range(0, 255)));
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) d[k] = 9'h000;
        test_reset();
        test_frame(0, 9'h06C);
        test_frame(1, 9'h088);
        test_frame(2, 9'h088);
        test_frame(3, 9'h1FF);
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 Parameter CLK_DIV, default 868, SHALL set clock cycles per bit; legal range is 2 to 65535.
REQ-003 Parameter DATA_BITS, default 8, SHALL set data bits per frame; legal range is 5 to 9.
REQ-004 Parameter PARITY, default 0, SHALL select parity: 0 none, 1 even, 2 odd.
REQ-005 Parameter STOP_BITS, default 1, SHALL set stop bits per frame; legal values are 1 and 2.
REQ-006 Parameter FIFO_DEPTH, default 4, SHALL set the input FIFO depth; it must be a power of 2 and at least 2.
REQ-007 Any illegal parameter value SHALL cause an elaboration error.
REQ-008 clk_i  input  1  SHALL be the system clock; all state updates on its rising edge.
REQ-009 reset_i  input  1  SHALL be the synchronous, active-high reset.
REQ-010 tx_data_i  input  DATA_BITS  SHALL be the word to transmit, sampled when valid_i and ready_o are both high.
REQ-011 valid_i  input  1  SHALL be the producer's request to write tx_data_i.
REQ-012 ready_o  output  1  SHALL indicate the FIFO can accept a word this cycle.
REQ-013 tx_o  output  1  SHALL be the serial line; idle high; driven from a register.
REQ-014 busy_o  output  1  SHALL be high while the FSM is not IDLE or the FIFO is non-empty.
REQ-015 level_o  output  $clog2(FIFO_DEPTH)+1  SHALL give the current FIFO occupancy.

Function
REQ-016 A word SHALL be accepted on a rising edge only when valid_i and ready_o are both high; when ready_o is low, valid_i SHALL be ignored.
REQ-017 ready_o SHALL be high exactly when registered level is below FIFO_DEPTH and reset_i is low; it SHALL NOT depend combinationally on valid_i or on a same-cycle pop.
REQ-018 A push and a pop on the same edge SHALL leave level unchanged and preserve FIFO order; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-020 IDLE -> START on the first edge where the FIFO is non-empty: pop the head word into the shift register and drive tx_o to 0.
REQ-021 A word written into an empty FIFO while in IDLE on edge N SHALL be popped on edge N+1, so tx_o falls after edge N+1.
REQ-022 Each bit SHALL last exactly CLK_DIV cycles, timed by a down-counter reloaded at every bit boundary.
REQ-023 START -> DATA: send DATA_BITS bits, LSB first.
REQ-024 DATA -> PARITY when PARITY != 0; otherwise DATA -> STOP.
REQ-025 The parity bit SHALL be the XOR of the data bits for even parity and the inverted XOR for odd parity.
REQ-026 STOP SHALL drive tx_o high for STOP_BITS*CLK_DIV cycles.
REQ-027 On the last STOP cycle, the FSM SHALL go to START with an immediate pop if the FIFO is non-empty (zero idle cycles between frames); otherwise it SHALL go to IDLE.
REQ-028 Frame length SHALL be (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * CLK_DIV cycles.
REQ-029 Data in the shift register SHALL be unaffected by later tx_data_i changes or FIFO writes.

Reset
REQ-030 While reset_i is high at a rising edge, the block SHALL enter IDLE, flush the FIFO and clear the bit counter.
REQ-031 After that edge: tx_o=1, busy_o=0, level_o=0, and ready_o=0 while reset_i remains high.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; tx_o SHALL be 1 after the next edge, and no partial bits SHALL resume after reset is released.
REQ-033 ready_o SHALL return to 1 in the first cycle after reset_i is sampled low.

Verification (bench uses CLK_DIV=4)
REQ-034 Case 1, 8N1: push 0x6C while idle. tx_o SHALL show 0 | 0,0,1,1,0,1,1,0 | 1, 4 cycles per bit, 40 cycles total; start bit begins 1 cycle after acceptance; busy_o falls after the stop bit.
REQ-035 Case 2, 8E1 and 8O1: push 0x88. The parity bit SHALL be 0 for even and 1 for odd; frame is 44 cycles.
REQ-036 Case 3, back-to-back, FIFO_DEPTH=4: hold valid_i high with 6 distinct words from idle.
- Exactly 5 SHALL be accepted before ready_o first falls.
- level_o SHALL reach 4.
- Frames SHALL be sent in order with no idle cycle between a stop bit and the next start bit.
- ready_o SHALL rise again only on the cycle after a pop.
REQ-037 Case 4, 9O2: push 0x1FF. Frame SHALL be 0, nine 1s, parity 0, then 1,1; 52 cycles total.
REQ-038 Case 5, reset mid-frame: during data bit 3 of a 0x55 frame, with 2 words queued, pulse reset_i for 1 cycle.
- Next edge SHALL give tx_o=1, level_o=0, busy_o=0.
- No further frames SHALL be sent.
- A new push afterwards SHALL transmit normally.
REQ-039 Case 6, full with simultaneous pop: with the FIFO full and valid_i high on the edge of a pop, the word presented SHALL NOT be accepted on that edge and SHALL be accepted on the following edge; no word SHALL be lost or duplicated.
